// File: rtl/cpu_issue_sequencer.sv
// rtl/cpu_issue_sequencer.sv - single-issue instruction sequencer with per-resource recovery tracking
//
// Steps each accepted instruction through FETCH -> DECODE -> EXECUTE, produces a
// one-cycle completion pulse with the computed result, and keeps the target
// resource busy for RECOV cycles after completion.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/req_ready              request handshake (accept = valid && ready at posedge)
//   req_addr, req_data               instruction address and operand
//   req_instr                        opcode: 0 NOP, 1 PASS, 2 INC, 3 DEC, 4 INV, 5-7 as PASS
//   req_res                          target resource index
//   mode                             0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE
//   busy                             per-resource recovery flags
//   done_valid/done_addr/done_result completion pulse and its held payload
//   stall_cnt                        saturating count of stalled request cycles
module cpu_issue_sequencer #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int N_RES    = 4,
  parameter int EXEC_LAT = 2,
  parameter int RECOV    = 3,
  localparam int RES_W   = (N_RES > 1) ? $clog2(N_RES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [2:0]        req_instr,
  input  logic [RES_W-1:0]  req_res,
  output logic [1:0]        mode,
  output logic [N_RES-1:0]  busy,
  output logic              done_valid,
  output logic [ADDR_W-1:0] done_addr,
  output logic [DATA_W-1:0] done_result,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_EXEC   = 2'd3;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam int ECNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
  localparam int RCNT_W = (RECOV > 0) ? $clog2(RECOV + 1) : 1;

  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic [2:0]        cap_instr;
  logic [RES_W-1:0]  cap_res;
  logic [ECNT_W-1:0] ecnt;
  logic [RCNT_W-1:0] rcnt [N_RES];
  logic [DATA_W-1:0] exec_result;
  logic              complete;
  logic              res_ok;
  logic              busy_sel;
  logic [31:0]       req_res_ext;

  // Resource range check is done at 32 bits so a non-power-of-two N_RES
  // rejects the unused encodings.
  assign req_res_ext = 32'(req_res);
  assign res_ok      = (req_res_ext < 32'(N_RES));

  // Loop-based select keeps out-of-range indices from addressing past busy[].
  always_comb begin
    busy_sel = 1'b0;
    for (int i = 0; i < N_RES; i++) begin
      if (req_res_ext == 32'(i)) busy_sel = busy[i];
    end
  end

  assign req_ready = !rst && (mode == S_IDLE) && res_ok && !busy_sel;

  always_comb begin
    exec_result = cap_data;
    case (cap_instr)
      OP_INC:  exec_result = cap_data + DATA_W'(1);
      OP_DEC:  exec_result = cap_data - DATA_W'(1);
      OP_INV:  exec_result = ~cap_data;
      default: exec_result = cap_data;
    endcase
  end

  assign complete = (mode == S_EXEC) && (ecnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode        <= S_IDLE;
      ecnt        <= '0;
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_instr   <= '0;
      cap_res     <= '0;
      done_valid  <= 1'b0;
      done_addr   <= '0;
      done_result <= '0;
    end else begin
      done_valid <= 1'b0;
      case (mode)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            cap_addr  <= req_addr;
            cap_data  <= req_data;
            cap_instr <= req_instr;
            cap_res   <= req_res;
            mode      <= S_FETCH;
          end
        end
        S_FETCH: mode <= S_DECODE;
        S_DECODE: begin
          if (cap_instr == OP_NOP) begin
            mode <= S_IDLE;
          end else begin
            mode <= S_EXEC;
            ecnt <= ECNT_W'(EXEC_LAT - 1);
          end
        end
        S_EXEC: begin
          if (complete) begin
            mode        <= S_IDLE;
            done_valid  <= 1'b1;
            done_addr   <= cap_addr;
            done_result <= exec_result;
          end else begin
            ecnt <= ecnt - ECNT_W'(1);
          end
        end
        default: mode <= S_IDLE;
      endcase
    end
  end

  // Loading RECOV at the completion edge makes busy high for exactly RECOV
  // cycles starting with the done_valid cycle; RECOV=0 loads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_RES; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_RES; i++) begin
        if (complete && (32'(cap_res) == 32'(i))) begin
          rcnt[i] <= RCNT_W'(RECOV);
        end else if (rcnt[i] != '0) begin
          rcnt[i] <= rcnt[i] - RCNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_RES; i++) busy[i] = (rcnt[i] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (req_valid && !req_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_issue_sequencer.sv
// tb/tb_cpu_issue_sequencer.sv - scoreboard bench for cpu_issue_sequencer
module tb_cpu_issue_sequencer;

  localparam int EXEC_LAT = 2;
  localparam int RECOV    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic [2:0]  req_instr;
  logic [1:0]  req_res;
  logic [1:0]  mode;
  logic [3:0]  busy;
  logic        done_valid;
  logic [15:0] done_addr;
  logic [15:0] done_result;
  logic [15:0] stall_cnt;

  cpu_issue_sequencer #(
    .ADDR_W(16), .DATA_W(16), .N_RES(4), .EXEC_LAT(EXEC_LAT), .RECOV(RECOV)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_instr(req_instr), .req_res(req_res),
    .mode(mode), .busy(busy),
    .done_valid(done_valid), .done_addr(done_addr), .done_result(done_result),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] result;
    int          d;
  } exp_t;

  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  // Reference model state, in absolute cycle numbers.
  int next_idle;
  int ready_at [4];
  int busy_from [4];
  int cur_e;
  bit cur_nop;
  int exp_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] d);
    case (op)
      3'd2:    return d + 16'd1;
      3'd3:    return d - 16'd1;
      3'd4:    return ~d;
      default: return d;
    endcase
  endfunction

  function automatic logic [1:0] exp_mode(input int c);
    if (c == cur_e) return 2'd1;
    if (c == cur_e + 1) return 2'd2;
    if (!cur_nop && c >= cur_e + 2 && c < cur_e + 2 + EXEC_LAT) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    next_idle = 0;
    for (int i = 0; i < 4; i++) begin
      ready_at[i]  = 0;
      busy_from[i] = 0;
    end
    cur_e     = -100;
    cur_nop   = 1'b0;
    exp_stall = 0;
    sbq.delete();
  endtask

  task automatic cycle_step(input bit v, input logic [15:0] a, input logic [15:0] d,
                            input logic [2:0] op, input logic [1:0] r);
    bit         rdy;
    logic [3:0] eb;
    int         e;
    int         dn;
    exp_t       x;
    @(negedge clk);
    req_valid = v; req_addr = a; req_data = d; req_instr = op; req_res = r;
    #1;
    rdy = (cyc >= next_idle) && (cyc >= ready_at[r]);
    for (int i = 0; i < 4; i++) eb[i] = (cyc >= busy_from[i]) && (cyc < ready_at[i]);
    chk("mode", 32'(mode), 32'(exp_mode(cyc)));
    chk("busy", 32'(busy), 32'(eb));
    chk("req_ready", 32'(req_ready), 32'(rdy));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    if (v && !rdy && exp_stall < 65535) exp_stall++;
    if (v && rdy) begin
      e       = cyc + 1;
      cur_e   = e;
      cur_nop = (op == 3'd0);
      if (op == 3'd0) begin
        next_idle = e + 2;
      end else begin
        dn           = e + 2 + EXEC_LAT;
        next_idle    = dn;
        busy_from[r] = dn;
        ready_at[r]  = dn + RECOV;
        x.addr   = a;
        x.result = ref_result(op, d);
        x.d      = dn;
        sbq.push_back(x);
      end
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) cycle_step(1'b0, 16'h0, 16'h0, 3'd0, 2'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("mode_exec_before_rst", 32'(mode), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_addr", 32'(done_addr), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_valid) begin
        if (sbq.size() == 0) begin
          chk("done_unexpected", 32'(done_valid), 32'd0);
        end else begin
          exp_t x;
          x = sbq.pop_front();
          chk("done_addr", 32'(done_addr), 32'(x.addr));
          chk("done_result", 32'(done_result), 32'(x.result));
          chk("done_cycle", 32'(cyc), 32'(x.d));
        end
      end else if (sbq.size() > 0 && sbq[0].d <= cyc) begin
        chk("done_missing", 32'(done_valid), 32'd1);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_instr = '0; req_res = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    chk("init_mode", 32'(mode), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done_valid", 32'(done_valid), 32'd0);
    chk("init_done_addr", 32'(done_addr), 32'd0);
    chk("init_done_result", 32'(done_result), 32'd0);
    chk("init_stall", 32'(stall_cnt), 32'd0);
    chk("init_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // INC then DEC to the same resource: three recovery stall cycles.
    cycle_step(1'b1, 16'h1000, 16'h00FF, 3'd2, 2'd1);
    idle_steps(4);
    repeat (4) cycle_step(1'b1, 16'h1004, 16'h0000, 3'd3, 2'd1);
    idle_steps(10);
    chk("stall_after_same_res", 32'(stall_cnt), 32'd3);

    // INC res1, then INV to res2 in the done cycle: accepted at once.
    cycle_step(1'b1, 16'h2000, 16'h1234, 3'd2, 2'd1);
    idle_steps(4);
    cycle_step(1'b1, 16'h2004, 16'hA5A5, 3'd4, 2'd2);
    idle_steps(10);
    chk("stall_after_other_res", 32'(stall_cnt), 32'd3);

    // NOP: back to IDLE without completion or busy.
    cycle_step(1'b1, 16'h3000, 16'h5555, 3'd0, 2'd0);
    idle_steps(6);

    // Reset during EXECUTE abandons the instruction.
    cycle_step(1'b1, 16'h4000, 16'h7777, 3'd2, 2'd0);
    cycle_step(1'b1, 16'h4004, 16'h1111, 3'd1, 2'd1);
    cycle_step(1'b1, 16'h4004, 16'h1111, 3'd1, 2'd1);
    pulse_reset();
    idle_steps(8);

    // Random traffic including reserved opcodes.
    for (int i = 0; i < 1500; i++) begin
      cycle_step(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end

    // Saturation: hold requests to res3 so most cycles stall.
    for (int i = 0; i < 75600; i++) begin
      cycle_step(1'b1, 16'($urandom), 16'($urandom), 3'($urandom_range(1, 7)), 2'd3);
    end
    chk("stall_saturated", 32'(stall_cnt), 32'hFFFF);

    idle_steps(12);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
